window_gen: RTL

//  Producer side of the conv filter-layer window input. Accepts a raster pixel stream and emits FN x FN

---
 rtl/cnn_pkg.sv | 14 +
 rtl/line_buf_row.sv | 25 ++
 rtl/window_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the conv front end: default sample width, window edge and
// the helper that locates x_<j>_<i> inside a flat window bus.
package cnn_pkg;

    localparam int CNN_WIDTH = 16;
    localparam int CNN_FN    = 3;
    localparam int CNN_WIN_W = CNN_FN * CNN_FN * CNN_WIDTH;

    // Bit offset of x_<j>_<i> (row j, column i) in a flat fn x fn window bus.
    function automatic int win_idx(input int j, input int i, input int fn, input int width);
        return (j * fn + i) * width;
    endfunction

endpackage

// File: rtl/line_buf_row.sv
// One image row of delayed pixels: combinational read of the old sample at col,
// new sample written at the same index on the clock edge (read-before-write).
module line_buf_row #(
    parameter int WIDTH = 16,
    parameter int IMG_W = 32,
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [CW-1:0]    col,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [IMG_W];

    assign rdata = mem[col];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[col] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen.sv
// Raster pixel stream to FN x FN sliding window generator feeding the conv filter layer.
// Define STRIDE2_EN to emit only windows whose top-left corner has even row and column.
module window_gen
    import cnn_pkg::*;
#(
    parameter int WIDTH = CNN_WIDTH,
    parameter int FN    = CNN_FN,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [FN*FN*WIDTH-1:0]  win_data,
    output logic                    win_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN = CW'(FN - 1);
    localparam logic [RW-1:0] ROW_MIN = RW'(FN - 1);
`ifdef STRIDE2_EN
    localparam logic [CW-1:0] LAST_C     = CW'(FN - 1 + 2 * ((IMG_W - FN) / 2));
    localparam logic [RW-1:0] LAST_R     = RW'(FN - 1 + 2 * ((IMG_H - FN) / 2));
    localparam logic          ANCHOR_PAR = 1'((FN - 1) % 2);
`else
    localparam logic [CW-1:0] LAST_C = COL_MAX;
    localparam logic [RW-1:0] LAST_R = ROW_MAX;
`endif

    // Handshake: a pixel transfers on a rising edge with in_valid && in_ready; a window
    // transfers on a rising edge with win_valid && win_ready. win_valid, win_data and
    // win_last stay stable until the window transfers; in_ready never waits on in_valid.
    logic                   accept;
    logic                   emit;
    logic                   at_last;
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [CW-1:0]          pix_col;
    logic [RW-1:0]          pix_row;
    logic [WIDTH-1:0]       lb_rd   [FN-1];
    logic [WIDTH-1:0]       new_col [FN];
    logic [WIDTH-1:0]       hist    [FN][FN-1];
    logic [FN*FN*WIDTH-1:0] next_win;

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;
    assign pix_col  = in_sof ? '0 : col;
    assign pix_row  = in_sof ? '0 : row;
    assign at_last  = (pix_row == LAST_R) && (pix_col == LAST_C);

    always_comb begin
        emit = accept && (pix_row >= ROW_MIN) && (pix_col >= COL_MIN);
`ifdef STRIDE2_EN
        emit = emit && (pix_row[0] == ANCHOR_PAR) && (pix_col[0] == ANCHOR_PAR);
`endif
    end

    // Cascaded row memories: row k returns the pixel k+1 lines above the current one.
    for (genvar k = 0; k < FN - 1; k++) begin : g_lb
        if (k == 0) begin : g_first
            line_buf_row #(.WIDTH(WIDTH), .IMG_W(IMG_W), .CW(CW)) u_row (
                .clk   (clk),
                .we    (accept),
                .col   (pix_col),
                .wdata (in_data),
                .rdata (lb_rd[k])
            );
        end else begin : g_next
            line_buf_row #(.WIDTH(WIDTH), .IMG_W(IMG_W), .CW(CW)) u_row (
                .clk   (clk),
                .we    (accept),
                .col   (pix_col),
                .wdata (lb_rd[k-1]),
                .rdata (lb_rd[k])
            );
        end
    end

    always_comb begin
        new_col[FN-1] = in_data;
        for (int j = 0; j < FN - 1; j++) begin
            new_col[j] = lb_rd[FN-2-j];
        end
    end

    // hist keeps the newest FN-1 columns; the window leaving column 0 is only needed in win_data.
    for (genvar j = 0; j < FN; j++) begin : g_row
        for (genvar i = 0; i < FN; i++) begin : g_col
            if (i < FN - 1) begin : g_old
                assign next_win[win_idx(j, i, FN, WIDTH) +: WIDTH] = hist[j][i];
            end else begin : g_new
                assign next_win[win_idx(j, i, FN, WIDTH) +: WIDTH] = new_col[j];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < FN; j++) begin
                for (int i = 0; i < FN - 1; i++) begin
                    hist[j][i] <= '0;
                end
            end
        end else if (accept) begin
            for (int j = 0; j < FN; j++) begin
                for (int i = 0; i < FN - 1; i++) begin
                    hist[j][i] <= next_win[win_idx(j, i + 1, FN, WIDTH) +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (pix_col == COL_MAX) begin
                col <= '0;
                row <= (pix_row == ROW_MAX) ? '0 : pix_row + 1'b1;
            end else begin
                col <= pix_col + 1'b1;
                row <= pix_row;
            end
        end
    end

    // Single output register; a new window may replace the one leaving in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_data  <= '0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_last  <= at_last;
            win_data  <= next_win;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule
